// File: rtl/bitwise_alu_if.sv
// Operand/result handshake bundle for bitwise_alu_seq.
// The z_par signal exists only when BWALU_PARITY_EN is defined.
`timescale 1ns/1ps
interface bitwise_alu_if #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [2:0]       op;
   logic             acc_en;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] z;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] txn_cnt;
`ifdef BWALU_PARITY_EN
   logic             z_par;
`endif

   modport master (
`ifdef BWALU_PARITY_EN
      input  z_par,
`endif
      output in_valid, x, y, op, acc_en, acc_clr, out_ready,
      input  in_ready, out_valid, z, acc, txn_cnt
   );

   modport slave (
`ifdef BWALU_PARITY_EN
      output z_par,
`endif
      input  in_valid, x, y, op, acc_en, acc_clr, out_ready,
      output in_ready, out_valid, z, acc, txn_cnt
   );
endinterface

// File: rtl/bitwise_alu_seq.sv
// Registered bitwise ALU with valid/ready handshake, accumulator and beat counter.
// Optional build macro BWALU_PARITY_EN adds z_par, the XOR-reduction of z.
`timescale 1ns/1ps
module bitwise_alu_seq #(
   parameter int unsigned WIDTH    = 3,
   parameter logic [63:0] ACC_INIT = 64'd0,
   parameter int unsigned CNT_W    = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   bitwise_alu_if.slave bus
);

   localparam logic [WIDTH-1:0] ACC_RST = ACC_INIT[WIDTH-1:0];

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   function automatic logic [WIDTH-1:0] bw_op(
      input logic [2:0]       sel,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      case (sel)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         3'd6:    return ~a;
         default: return b;
      endcase
   endfunction

   state_t           state_p1;
   state_t           state_nxt;
   logic             accept_p0;
   logic             consume_p0;
   logic             in_ready_p0;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] res_p0;
   logic [WIDTH-1:0] z_p1;
   logic [WIDTH-1:0] acc_p1;
   logic [CNT_W-1:0] cnt_p1;

   // Stage p0: operand select, operation and handshake decode
   assign in_ready_p0 = (state_p1 == S_EMPTY) || bus.out_ready;
   assign accept_p0   = bus.in_valid && in_ready_p0;
   assign consume_p0  = (state_p1 == S_FULL) && bus.out_ready;
   assign a_p0        = bus.acc_en ? acc_p1 : bus.x;
   assign res_p0      = bw_op(bus.op, a_p0, bus.y);

   always_comb begin
      state_nxt = state_p1;
      if (accept_p0) begin
         state_nxt = S_FULL;
      end else if (consume_p0) begin
         state_nxt = S_EMPTY;
      end
   end

   // Stage p1: result register, accumulator and counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_p1 <= S_EMPTY;
      end else begin
         state_p1 <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         z_p1 <= '0;
      end else if (accept_p0) begin
         z_p1 <= res_p0;
      end
   end

   // A clear wins over an accumulate, but the beat still used the old acc.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_p1 <= ACC_RST;
      end else if (bus.acc_clr) begin
         acc_p1 <= ACC_RST;
      end else if (accept_p0 && bus.acc_en) begin
         acc_p1 <= res_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_p1 <= '0;
      end else if (accept_p0) begin
         cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
   end

`ifdef BWALU_PARITY_EN
   logic z_par_p1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         z_par_p1 <= 1'b0;
      end else if (accept_p0) begin
         z_par_p1 <= ^res_p0;
      end
   end

   assign bus.z_par = z_par_p1;
`endif

   assign bus.in_ready  = in_ready_p0;
   assign bus.out_valid = (state_p1 == S_FULL);
   assign bus.z         = z_p1;
   assign bus.acc       = acc_p1;
   assign bus.txn_cnt   = cnt_p1;

endmodule

// File: doc/bitwise_alu_seq.md
Name: bitwise_alu_seq

Overview:
- Parametrised, registered successor to the 3-bit combinational bitwise unit.
- Applies one of eight bitwise operations to two WIDTH-bit operands and holds the result in an output register.
- Has a valid/ready handshake on both sides, an accumulate mode that feeds the result back as operand A, and a wrapping count of completed transactions.
- Sits between an operand source and a downstream consumer in the datapath test fabric.

Parameters:
- WIDTH, 3, operand and result width in bits (1..64).
- ACC_INIT, 0, accumulator value after reset or clear (WIDTH bits, zero-extended/truncated).
- CNT_W, 8, width of the transaction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  block can accept a beat this cycle
- x  input  WIDTH  operand A (ignored when acc_en=1)
- y  input  WIDTH  operand B
- op  input  3  operation select, sampled with the beat
- acc_en  input  1  use accumulator as operand A and update it with the result
- acc_clr  input  1  load ACC_INIT into the accumulator (one-cycle pulse, independent of handshake)
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer takes the result this cycle
- z  output  WIDTH  registered result
- acc  output  WIDTH  current accumulator value
- txn_cnt  output  CNT_W  number of accepted input beats, modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, z=0, acc=ACC_INIT, txn_cnt=0.
  - Reset dominates all other inputs, including mid-transfer; any held result is discarded.
- op encoding, with A = (acc_en ? acc : x) and B = y:
  - 0 A&B; 1 A|B; 2 A^B; 3 ~(A&B); 4 ~(A|B); 5 ~(A^B); 6 ~A; 7 B.
  - All results are exactly WIDTH bits; no carries.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid).
  - A beat is accepted when in_valid && in_ready at a clk edge. On acceptance: z <= f(A,B), out_valid <= 1, txn_cnt <= txn_cnt+1.
  - txn_cnt wraps from 2^CNT_W-1 to 0.
  - Result latency is 1 cycle: z and out_valid update on the edge that accepts the beat.
  - A result is consumed when out_valid && out_ready. If there is no simultaneous accept, out_valid <= 0 and z holds its value.
  - Simultaneous consume and accept gives full throughput: out_valid stays 1 and z takes the new result.
  - When out_valid=1 and out_ready=0, z, out_valid and acc hold, and in_ready=0.
- Accumulator:
  - On an accepted beat with acc_en=1: acc <= f(acc,y) in the same cycle as z (z equals the new acc).
  - acc_en=0 leaves acc unchanged.
  - acc_clr=1 loads ACC_INIT and has priority over an accumulate update in the same cycle. The accepted beat still computes from the pre-clear acc and z is still written.
- Inputs are don't-care while in_valid=0. x, y and op are not required to be stable after acceptance.

Optional Feature:
- Macro BWALU_PARITY_EN.
- When defined:
  - Adds output z_par (1 bit) = XOR-reduction of z, registered with z.
  - z_par resets to 0 and holds whenever z holds.
- When undefined, the port and logic are absent.
- All other behaviour is identical in both builds.

Test Plan:
- WIDTH=3. Reset, then x=3, y=4, op=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, z=0, txn_cnt=1.
- x=7, y=5 sequenced with op=1,2,3,4,5,6,7 back-to-back, out_ready=1 -> z = 7,2,2,0,5,0,5 on consecutive cycles, in_ready stays 1.
- Accept x=0, y=1, op=1; hold out_ready=0 for 3 cycles -> in_ready=0, z=1 and out_valid=1 held. Raise out_ready together with a new beat x=3, y=3, op=2 -> z=0 the following cycle.
- acc_en=1, ACC_INIT=0: beats y=1 op=1, y=6 op=2, y=3 op=0 -> z/acc = 1, 7, 3. Pulse acc_clr alone -> acc=0.
- Accept 256 beats with CNT_W=8 -> txn_cnt wraps to 0. Assert rst_n=0 while out_valid=1 -> next cycle out_valid=0, z=0, txn_cnt=0.
- With BWALU_PARITY_EN defined: result z=7 -> z_par=1; result z=5 -> z_par=0.
